// File: rtl/tis_pkg.sv
// Shared definitions for the stream checker: word type, global state
// encoding, error-counter width and a saturating add for that counter.
// No ports (package).
package tis_pkg;

  localparam int ERRCNT_W  = 16;
  localparam int TIS_WIDTH = 11;

  typedef logic signed [TIS_WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  // Adds inc to base, pinning the result at all-ones instead of wrapping.
  function automatic logic [ERRCNT_W-1:0] sat_add_err(
    input logic [ERRCNT_W-1:0] base,
    input logic [ERRCNT_W-1:0] inc
  );
    logic [ERRCNT_W:0] sum;
    sum = {1'b0, base} + {1'b0, inc};
    if (sum[ERRCNT_W]) begin
      sat_add_err = {ERRCNT_W{1'b1}};
    end else begin
      sat_add_err = sum[ERRCNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/stream_checker_if.sv
// Producer-side stream bundle for the stream checker.
//   rready[c] : producer has a word on in[c]
//   in[c]     : producer data word for lane c
//   read[c]   : checker accepted the word on lane c this cycle
// master = producer, slave = checker.
interface stream_checker_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 11
);
  logic [CHANNELS-1:0]            rready;
  logic [CHANNELS-1:0][WIDTH-1:0] in;
  logic [CHANNELS-1:0]            read;

  modport master (output rready, output in, input read);
  modport slave  (input rready, input in, output read);
endinterface

// File: rtl/stream_lane.sv
// One checker lane: expected-word RAM, programmed length, and the running
// index/complete/mismatch/stopped status of a single output stream.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   clear             : sync status clear (RAM and length kept)
//   start_run         : IDLE->RUN this cycle; re-arms the lane
//   run               : global state is RUN
//   load_wr/addr/data : expected-word write (already qualified by top)
//   len_wr/load_len   : length write (already qualified by top)
//   rready/data       : producer handshake for this lane
//   read              : word accepted this cycle (combinational)
//   complete/mismatch/stopped : lane status
//   mism_pulse        : accepted word differed from expected
//   index             : index of the word currently expected
module stream_lane
  import tis_pkg::*;
#(
  parameter  int WIDTH            = 11,
  parameter  int DEPTH            = 39,
  parameter  int STOP_ON_MISMATCH = 1,
  localparam int AW               = $clog2(DEPTH),
  localparam int LW               = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start_run,
  input  logic             run,
  input  logic             load_wr,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             len_wr,
  input  logic [LW-1:0]    load_len,
  input  logic             rready,
  input  logic [WIDTH-1:0] data,
  output logic             read,
  output logic             complete,
  output logic             mismatch,
  output logic             stopped,
  output logic             mism_pulse,
  output logic [LW-1:0]    index
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [LW-1:0]    len_r;
  logic [LW-1:0]    index_r;
  logic             complete_r;
  logic             mismatch_r;
  logic             stopped_r;

  logic [AW-1:0]    rd_addr_s;
  logic [LW-1:0]    index_inc_s;
  logic             xfer_s;
  logic             differ_s;

  // Handshake and compare against the asynchronously read expected word.
  always_comb begin
    rd_addr_s   = index_r[AW-1:0];
    index_inc_s = index_r + LW'(1);
    xfer_s      = run & rready & ~complete_r & ~stopped_r;
    differ_s    = (data != mem_r[rd_addr_s]);
  end

  // Expected-word RAM; deliberately not reset so data survives rst_n/clear.
  always_ff @(posedge clk) begin
    if (load_wr && (int'(load_addr) < DEPTH)) begin
      mem_r[load_addr] <= load_data;
    end
  end

  // Lane length; oversize requests clamp to DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_r <= '0;
    end else if (len_wr) begin
      len_r <= (int'(load_len) > DEPTH) ? LW'(DEPTH) : load_len;
    end
  end

  // Lane progress; a zero-length lane is complete as soon as RUN begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_r    <= '0;
      complete_r <= 1'b0;
      mismatch_r <= 1'b0;
      stopped_r  <= 1'b0;
    end else if (clear) begin
      index_r    <= '0;
      complete_r <= 1'b0;
      mismatch_r <= 1'b0;
      stopped_r  <= 1'b0;
    end else if (start_run) begin
      index_r    <= '0;
      complete_r <= (len_r == LW'(0));
      mismatch_r <= 1'b0;
      stopped_r  <= 1'b0;
    end else if (xfer_s) begin
      index_r <= index_inc_s;
      if (index_inc_s == len_r) begin
        complete_r <= 1'b1;
      end
      if (differ_s) begin
        mismatch_r <= 1'b1;
        stopped_r  <= stopped_r | (STOP_ON_MISMATCH != 0);
      end
    end
  end

  assign read       = xfer_s;
  assign mism_pulse = xfer_s & differ_s;
  assign complete   = complete_r;
  assign mismatch   = mismatch_r;
  assign stopped    = stopped_r;
  assign index      = index_r;

endmodule

// File: rtl/stream_checker.sv
// Multi-lane output-stream checker. Compares CHANNELS producer streams
// against runtime-loaded expected data and reports pass/fail/timeout.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start, clear        : run control (clear wins over start and transfers)
//   load_en/ch/addr/data: expected-word load (IDLE only)
//   len_en/load_len     : lane length load (IDLE only)
//   strm                : producer stream bundle (rready, in, read)
//   complete, mismatch  : per-lane status
//   err_count           : saturating total of mismatched words
//   done, pass, timeout : final verdict flags
//   first_err_*         : lane, index and value of the first mismatch
module stream_checker
  import tis_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int WIDTH            = 11,
  parameter int DEPTH            = 39,
  parameter int TIMEOUT_CYCLES   = 2**20,
  parameter int STOP_ON_MISMATCH = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         load_en,
  input  logic [$clog2(CHANNELS)-1:0]  load_ch,
  input  logic [$clog2(DEPTH)-1:0]     load_addr,
  input  logic [WIDTH-1:0]             load_data,
  input  logic                         len_en,
  input  logic [$clog2(DEPTH+1)-1:0]   load_len,
  stream_checker_if.slave              strm,
  output logic [CHANNELS-1:0]          complete,
  output logic [CHANNELS-1:0]          mismatch,
  output logic [ERRCNT_W-1:0]          err_count,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [$clog2(CHANNELS)-1:0]  first_err_ch,
  output logic [$clog2(DEPTH)-1:0]     first_err_idx,
  output logic [WIDTH-1:0]             first_err_got
);

  localparam int CHW = $clog2(CHANNELS);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);

  state_t state_r, state_nxt_s;
  logic   done_r, pass_r, timeout_r;
  logic [CW-1:0] idle_cnt_r;
  logic [ERRCNT_W-1:0] err_count_r;
  logic captured_r;
  logic [CHW-1:0]   first_ch_r;
  logic [AW-1:0]    first_idx_r;
  logic [WIDTH-1:0] first_got_r;

  logic in_idle_s, in_run_s, start_run_s;
  logic [CHANNELS-1:0] read_s, mism_s, stopped_s, complete_s, mismatch_s;
  logic [LW-1:0] lane_idx_s [CHANNELS];
  logic hit_s;
  logic [CHW-1:0] hit_ch_s;
  logic [AW-1:0] hit_idx_s;
  logic [WIDTH-1:0] hit_got_s;
  logic [ERRCNT_W-1:0] mism_cnt_s;

  assign in_idle_s   = (state_r == ST_IDLE);
  assign in_run_s    = (state_r == ST_RUN);
  assign start_run_s = in_idle_s & start & ~clear;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    stream_lane #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .STOP_ON_MISMATCH(STOP_ON_MISMATCH)
    ) u_lane (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .start_run(start_run_s), .run(in_run_s),
      .load_wr(load_en & in_idle_s & (load_ch == CHW'(c))),
      .load_addr(load_addr), .load_data(load_data),
      .len_wr(len_en & in_idle_s & (load_ch == CHW'(c))),
      .load_len(load_len),
      .rready(strm.rready[c]), .data(strm.in[c]),
      .read(read_s[c]), .complete(complete_s[c]), .mismatch(mismatch_s[c]),
      .stopped(stopped_s[c]), .mism_pulse(mism_s[c]), .index(lane_idx_s[c])
    );
  end

  // Global next state; clear overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) state_nxt_s = ST_RUN;
          else       state_nxt_s = ST_IDLE;
        end
        ST_RUN: begin
          if (&complete_s) begin
            if (|mismatch_s) state_nxt_s = ST_FAIL;
            else             state_nxt_s = ST_PASS;
          end else if ((STOP_ON_MISMATCH != 0) && (&(complete_s | stopped_s))) begin
            state_nxt_s = ST_FAIL;
          end else if ((idle_cnt_r == CW'(TIMEOUT_CYCLES - 1)) && !(|read_s)) begin
            // This idle cycle is the TIMEOUT_CYCLES-th since the last transfer.
            state_nxt_s = ST_TIMEOUT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_PASS:    state_nxt_s = ST_PASS;
        ST_FAIL:    state_nxt_s = ST_FAIL;
        ST_TIMEOUT: state_nxt_s = ST_TIMEOUT;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State register with verdict flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      done_r    <= (state_nxt_s == ST_PASS) || (state_nxt_s == ST_FAIL) ||
                   (state_nxt_s == ST_TIMEOUT);
      pass_r    <= (state_nxt_s == ST_PASS);
      timeout_r <= (state_nxt_s == ST_TIMEOUT);
    end
  end

  // Stall counter: counts RUN cycles since the last transfer on any lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_r <= '0;
    end else if (clear || !in_run_s || (|read_s)) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_r + CW'(1);
    end
  end

  // Lowest-numbered mismatching lane this cycle, plus mismatch count.
  always_comb begin
    hit_s      = 1'b0;
    hit_ch_s   = '0;
    hit_idx_s  = '0;
    hit_got_s  = '0;
    mism_cnt_s = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      mism_cnt_s = mism_cnt_s + ERRCNT_W'(mism_s[c]);
      if (mism_s[c]) begin
        hit_s     = 1'b1;
        hit_ch_s  = CHW'(c);
        hit_idx_s = lane_idx_s[c][AW-1:0];
        hit_got_s = strm.in[c];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Error total and one-shot capture of the first mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_r <= '0;
      captured_r  <= 1'b0;
      first_ch_r  <= '0;
      first_idx_r <= '0;
      first_got_r <= '0;
    end else if (clear) begin
      err_count_r <= '0;
      captured_r  <= 1'b0;
      first_ch_r  <= '0;
      first_idx_r <= '0;
      first_got_r <= '0;
    end else begin
      if (hit_s) begin
        err_count_r <= sat_add_err(err_count_r, mism_cnt_s);
      end
      if (hit_s && !captured_r) begin
        captured_r  <= 1'b1;
        first_ch_r  <= hit_ch_s;
        first_idx_r <= hit_idx_s;
        first_got_r <= hit_got_s;
      end
    end
  end

  assign strm.read     = read_s;
  assign complete      = complete_s;
  assign mismatch      = mismatch_s;
  assign err_count     = err_count_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign timeout       = timeout_r;
  assign first_err_ch  = first_ch_r;
  assign first_err_idx = first_idx_r;
  assign first_err_got = first_got_r;

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: instance a stops lanes on mismatch,
// instance b keeps consuming; both use a 16-cycle stall timeout.
module tb_stream_checker;
  import tis_pkg::*;

  localparam int CH = 4;
  localparam int W  = 11;
  localparam int D  = 39;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0, start = 1'b0, clear = 1'b0, load_en = 1'b0, len_en = 1'b0;
  logic [1:0]  load_ch = 2'd0;
  logic [5:0]  load_addr = 6'd0;
  logic [10:0] load_data = 11'd0;
  logic [5:0]  load_len = 6'd0;
  logic [3:0]  rdy_a = 4'd0, rdy_b = 4'd0;
  logic [3:0][10:0] dat = '0;

  logic [3:0] cmp_a, mis_a, cmp_b, mis_b;
  logic [15:0] errc_a, errc_b;
  logic done_a, pass_a, to_a, done_b, pass_b, to_b;
  logic [1:0] fch_a, fch_b;
  logic [5:0] fidx_a, fidx_b;
  logic [10:0] fgot_a, fgot_b;

  stream_checker_if #(.CHANNELS(CH), .WIDTH(W)) if_a ();
  stream_checker_if #(.CHANNELS(CH), .WIDTH(W)) if_b ();
  assign if_a.rready = rdy_a;
  assign if_a.in     = dat;
  assign if_b.rready = rdy_b;
  assign if_b.in     = dat;

  stream_checker #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .TIMEOUT_CYCLES(TO),
                   .STOP_ON_MISMATCH(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .load_en(load_en),
    .load_ch(load_ch), .load_addr(load_addr), .load_data(load_data),
    .len_en(len_en), .load_len(load_len), .strm(if_a),
    .complete(cmp_a), .mismatch(mis_a), .err_count(errc_a), .done(done_a),
    .pass(pass_a), .timeout(to_a), .first_err_ch(fch_a),
    .first_err_idx(fidx_a), .first_err_got(fgot_a));

  stream_checker #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .TIMEOUT_CYCLES(TO),
                   .STOP_ON_MISMATCH(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .load_en(load_en),
    .load_ch(load_ch), .load_addr(load_addr), .load_data(load_data),
    .len_en(len_en), .load_len(load_len), .strm(if_b),
    .complete(cmp_b), .mismatch(mis_b), .err_count(errc_b), .done(done_b),
    .pass(pass_b), .timeout(to_b), .first_err_ch(fch_b),
    .first_err_idx(fidx_b), .first_err_got(fgot_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [10:0] exp_w  [4][3];
  logic [10:0] send_w [4][3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int ch, input int addr, input logic [10:0] v);
    load_en = 1'b1; load_ch = 2'(ch); load_addr = 6'(addr); load_data = v;
    tick();
    load_en = 1'b0;
  endtask

  task automatic set_len(input int ch, input int n);
    len_en = 1'b1; load_ch = 2'(ch); load_len = 6'(n);
    tick();
    len_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic reset_send();
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 3; i++) send_w[c][i] = exp_w[c][i];
  endtask

  // Drives send_w into one instance; lanes in gap_mask only offer on even cycles.
  task automatic run_lanes(input bit use_b, input logic [3:0] gap_mask, input bit stop_mode);
    int idx [4];
    bit stp [4];
    logic [3:0] r;
    bit fin;
    for (int c = 0; c < 4; c++) begin idx[c] = 0; stp[c] = 1'b0; end
    fin = 1'b0;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      r = 4'd0;
      for (int c = 0; c < 4; c++) begin
        if (idx[c] < 3 && !stp[c] && (!gap_mask[c] || (cyc % 2) == 0)) begin
          r[c] = 1'b1;
          dat[c] = send_w[c][idx[c]];
        end
      end
      if (use_b) rdy_b = r; else rdy_a = r;
      #1;
      chk("read", use_b ? if_b.read : if_a.read, r);
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (r[c]) begin
          if (stop_mode && (send_w[c][idx[c]] !== exp_w[c][idx[c]])) stp[c] = 1'b1;
          idx[c]++;
        end
      end
      fin = 1'b1;
      for (int c = 0; c < 4; c++) if (idx[c] < 3 && !stp[c]) fin = 1'b0;
    end
    rdy_a = 4'd0;
    rdy_b = 4'd0;
    if (!fin) begin
      failures++;
      $display("FAIL lane_budget observed=unfinished expected=finished");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_w[0][0] = 11'd1;          exp_w[0][1] = 11'd2; exp_w[0][2] = 11'd3;
    exp_w[1][0] = 11'(-1);        exp_w[1][1] = 11'd0; exp_w[1][2] = 11'd1;
    exp_w[2][0] = 11'd5;          exp_w[2][1] = 11'd5; exp_w[2][2] = 11'd5;
    exp_w[3][0] = 11'd999;        exp_w[3][1] = 11'(-999); exp_w[3][2] = 11'd0;
    reset_send();

    // Reset state, with producers offering on every lane.
    rdy_a = 4'hF;
    #2;
    chk("rst_read", if_a.read, 4'h0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_pass", pass_a, 1'b0);
    chk("rst_timeout", to_a, 1'b0);
    chk("rst_complete", cmp_a, 4'h0);
    chk("rst_mismatch", mis_a, 4'h0);
    chk("rst_errcnt", errc_a, 16'h0);
    chk("rst_first_got", fgot_a, 11'h0);
    rdy_a = 4'h0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // Load expected data and lengths.
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 3; i++) load_word(c, i, exp_w[c][i]);
    for (int c = 0; c < 4; c++) set_len(c, 3);

    // Pass case, lanes 2/3 with gaps.
    pulse_start();
    run_lanes(1'b0, 4'b1100, 1'b1);
    chk("p_complete", cmp_a, 4'hF);
    chk("p_done_early", done_a, 1'b0);
    tick();
    chk("p_done", done_a, 1'b1);
    chk("p_pass", pass_a, 1'b1);
    chk("p_errcnt", errc_a, 16'h0);
    chk("p_mismatch", mis_a, 4'h0);
    pulse_start();
    chk("p_start_ignored", pass_a, 1'b1);

    // Single mismatch on lane 2 at index 1, stop-on-mismatch.
    pulse_clear();
    reset_send();
    send_w[2][1] = 11'd4;
    pulse_start();
    run_lanes(1'b0, 4'b0000, 1'b1);
    chk("s_mismatch", mis_a, 4'b0100);
    rdy_a = 4'b0100;
    dat[2] = 11'd5;
    #1;
    chk("s_read_held", if_a.read, 4'h0);
    tick();
    rdy_a = 4'h0;
    chk("s_done", done_a, 1'b1);
    chk("s_pass", pass_a, 1'b0);
    chk("s_timeout", to_a, 1'b0);
    chk("s_first_ch", fch_a, 2'd2);
    chk("s_first_idx", fidx_a, 6'd1);
    chk("s_first_got", fgot_a, 11'd4);
    chk("s_errcnt", errc_a, 16'd1);

    // Same-cycle mismatches on lanes 3 and 1, lanes keep consuming.
    pulse_clear();
    reset_send();
    send_w[1][1] = 11'd7;
    send_w[3][1] = 11'd100;
    pulse_start();
    run_lanes(1'b1, 4'b0000, 1'b0);
    chk("m_complete", cmp_b, 4'hF);
    chk("m_mismatch", mis_b, 4'b1010);
    chk("m_errcnt", errc_b, 16'd2);
    chk("m_first_ch", fch_b, 2'd1);
    chk("m_first_idx", fidx_b, 6'd1);
    chk("m_first_got", fgot_b, 11'd7);
    tick();
    chk("m_done", done_b, 1'b1);
    chk("m_pass", pass_b, 1'b0);

    // Stall timeout 16 cycles after the only transfer; a RUN-time load is ignored.
    pulse_clear();
    reset_send();
    pulse_start();
    rdy_a = 4'b0001;
    dat[0] = exp_w[0][0];
    #1;
    chk("t_read", if_a.read, 4'b0001);
    tick();
    rdy_a = 4'h0;
    load_word(0, 0, 11'd50);
    repeat (14) tick();
    chk("t_timeout_early", to_a, 1'b0);
    tick();
    chk("t_timeout", to_a, 1'b1);
    chk("t_done", done_a, 1'b1);
    chk("t_pass", pass_a, 1'b0);

    // All lengths zero: PASS one cycle after RUN, no reads.
    pulse_clear();
    for (int c = 0; c < 4; c++) set_len(c, 0);
    rdy_a = 4'hF;
    pulse_start();
    chk("z_read_run", if_a.read, 4'h0);
    chk("z_complete", cmp_a, 4'hF);
    chk("z_done_early", done_a, 1'b0);
    tick();
    chk("z_done", done_a, 1'b1);
    chk("z_pass", pass_a, 1'b1);
    chk("z_read_pass", if_a.read, 4'h0);
    rdy_a = 4'h0;

    // Async reset mid-run clears status immediately.
    pulse_clear();
    for (int c = 0; c < 4; c++) set_len(c, 3);
    pulse_start();
    for (int c = 0; c < 4; c++) dat[c] = exp_w[c][0];
    dat[0] = 11'd9;
    rdy_a = 4'hF;
    tick();
    chk("r_pre_mismatch", mis_a, 4'b0001);
    chk("r_pre_first_got", fgot_a, 11'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("r_mismatch", mis_a, 4'h0);
    chk("r_errcnt", errc_a, 16'h0);
    chk("r_first_got", fgot_a, 11'h0);
    chk("r_read", if_a.read, 4'h0);
    #1 rst_n = 1'b1;
    rdy_a = 4'h0;
    tick();

    // Clear mid-run clears status on the next edge.
    for (int c = 0; c < 4; c++) set_len(c, 3);
    pulse_start();
    rdy_a = 4'hF;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("c_mismatch", mis_a, 4'h0);
    chk("c_errcnt", errc_a, 16'h0);
    chk("c_complete", cmp_a, 4'h0);
    chk("c_read_idle", if_a.read, 4'h0);
    rdy_a = 4'h0;

    // Re-run on retained expected data.
    reset_send();
    pulse_start();
    run_lanes(1'b0, 4'b0101, 1'b1);
    tick();
    chk("rr_pass", pass_a, 1'b1);
    chk("rr_errcnt", errc_a, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
